// File: rtl/rx_capture_mem_if.sv
// APB3 slave bus bundle for the capture memory register window.
interface rx_capture_mem_if;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/rx_capture_mem.sv
// SPI receive capture buffer: APB-armed capture of LEN+1 12-bit words into a
// RAM that is then read back over APB.
module rx_capture_mem #(
  parameter int unsigned DEPTH = 128
) (
  input  logic              clk,
  input  logic              rstn,
  rx_capture_mem_if.slave   APB_S_0,
  output logic              RecSPIen,
  input  logic              rec_valid,
  input  logic [11:0]       data_from_SPI
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] count, count_nxt;
  logic [AW-1:0] len;
  logic          done, done_nxt;
  logic          overflow, overflow_nxt;
  logic          mem_we;
  logic          pready_q;
  logic [11:0]   rd_word;
  logic [31:0]   rdata;
  logic [11:0]   mem [DEPTH];

  logic [9:0] addr;
  logic       access, apb_wr, rd_en;
  logic       ctrl_wr, len_wr, start, abort;

  assign addr    = APB_S_0.paddr[9:0];
  assign access  = APB_S_0.psel && APB_S_0.penable;
  assign apb_wr  = access && APB_S_0.pwrite && pready_q;
  assign rd_en   = access && !pready_q && addr[9];
  assign ctrl_wr = apb_wr && (addr == 10'h000);
  assign len_wr  = apb_wr && (addr == 10'h004);
  // Abort outranks start when both control bits are written together.
  assign abort   = ctrl_wr && APB_S_0.pwdata[1];
  assign start   = ctrl_wr && APB_S_0.pwdata[0] && !APB_S_0.pwdata[1];

  logic unused_bits;
  assign unused_bits = &{1'b0, APB_S_0.paddr[31:10], APB_S_0.paddr[1:0],
                         APB_S_0.pwdata[31:AW]};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      count    <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
      len      <= '1;
      pready_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      done     <= done_nxt;
      overflow <= overflow_nxt;
      pready_q <= access && !pready_q;
      if (len_wr) len <= APB_S_0.pwdata[AW-1:0];
    end
  end

  always_comb begin
    state_nxt    = state;
    count_nxt    = count;
    done_nxt     = done;
    overflow_nxt = overflow;
    mem_we       = 1'b0;
    if (rec_valid && state != CAPTURE) overflow_nxt = 1'b1;
    if (abort) begin
      state_nxt = IDLE;
      done_nxt  = 1'b0;
    end else if (start) begin
      state_nxt    = CAPTURE;
      count_nxt    = '0;
      done_nxt     = 1'b0;
      overflow_nxt = 1'b0;
    end else if (state == CAPTURE && rec_valid) begin
      mem_we    = 1'b1;
      count_nxt = count + 1'b1;
      // Live LEN compare: a LEN below count lets count wrap round to it.
      if (count == len) begin
        state_nxt = DONE;
        done_nxt  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[count] <= data_from_SPI;
    if (rd_en)  rd_word    <= mem[APB_S_0.paddr[2 +: AW]];
  end

  always_comb begin
    rdata = '0;
    if (pready_q) begin
      if (addr[9]) begin
        rdata = {20'b0, rd_word};
      end else begin
        case (addr)
          10'h004: rdata = {25'b0, 7'(len)};
          10'h008: rdata = {15'b0, overflow, 1'b0, 7'(count), 6'b0, done,
                            state == CAPTURE};
          default: rdata = '0;
        endcase
      end
    end
  end

  assign APB_S_0.prdata  = rdata;
  assign APB_S_0.pready  = pready_q;
  assign APB_S_0.pslverr = 1'b0;
  assign RecSPIen        = (state == CAPTURE);

endmodule

// File: tb/tb_rx_capture_mem.sv
// Directed self-checking bench for rx_capture_mem.
module tb_rx_capture_mem;
  logic        clk = 1'b0;
  logic        rstn;
  logic        RecSPIen;
  logic        rec_valid;
  logic [11:0] data_from_SPI;

  rx_capture_mem_if bus ();

  rx_capture_mem #(.DEPTH(128)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .APB_S_0       (bus),
    .RecSPIen      (RecSPIen),
    .rec_valid     (rec_valid),
    .data_from_SPI (data_from_SPI)
  );

  always #5 clk = ~clk;

  int unsigned total  = 0;
  int unsigned passed = 0;
  int unsigned failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic strobe, input logic [11:0] sdata,
                          output logic [31:0] rdata, output int lat, output logic rdy_after);
    @(posedge clk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr;
    bus.paddr = addr; bus.pwdata = wdata;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus.pready && lat < 8);
    if (!bus.pready) check("pready_timeout", {31'b0, bus.pready}, 32'h1);
    rdata = bus.prdata;
    if (strobe) begin
      rec_valid = 1'b1;
      data_from_SPI = sdata;
    end
    @(posedge clk); #1;
    rdy_after = bus.pready;
    rec_valid = 1'b0;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] d; int l; logic r;
    apb_xfer(1'b1, addr, wdata, 1'b0, 12'h0, d, l, r);
  endtask

  task automatic apb_write_strobe(input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [11:0] sdata);
    logic [31:0] d; int l; logic r;
    apb_xfer(1'b1, addr, wdata, 1'b1, sdata, d, l, r);
  endtask

  task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d; int l; logic r;
    apb_xfer(1'b0, addr, 32'h0, 1'b0, 12'h0, d, l, r);
    check(tag, d, exp);
  endtask

  task automatic strobe(input logic [11:0] d);
    @(posedge clk); #1;
    rec_valid = 1'b1;
    data_from_SPI = d;
    @(posedge clk); #1;
    rec_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int          lat;
    logic        rdy_after;

    rstn = 1'b0; rec_valid = 1'b0; data_from_SPI = '0;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = '0; bus.pwdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_recspien", {31'b0, RecSPIen}, 32'h0);
    check("rst_pready", {31'b0, bus.pready}, 32'h0);
    check("rst_pslverr", {31'b0, bus.pslverr}, 32'h0);
    rstn = 1'b1;

    // LEN after reset, with exact pready timing
    apb_xfer(1'b0, 32'h004, 32'h0, 1'b0, 12'h0, d, lat, rdy_after);
    check("len_reset", d, 32'h0000_007F);
    check("pready_latency", lat, 32'd1);
    check("pready_one_cycle", {31'b0, rdy_after}, 32'h0);
    read_check("status_reset", 32'h008, 32'h0);

    // Basic 4-word capture
    apb_write(32'h004, 32'h3);
    apb_write(32'h000, 32'h1);
    check("armed", {31'b0, RecSPIen}, 32'h1);
    strobe(12'h111); strobe(12'h222); strobe(12'h333);
    check("armed_after3", {31'b0, RecSPIen}, 32'h1);
    strobe(12'h444);
    check("disarmed_after4", {31'b0, RecSPIen}, 32'h0);
    read_check("status_done4", 32'h008, 32'h0000_0402);
    read_check("buf0", 32'h200, 32'h111);
    read_check("buf1", 32'h204, 32'h222);
    read_check("buf2", 32'h208, 32'h333);
    read_check("buf3", 32'h20C, 32'h444);
    read_check("len3", 32'h004, 32'h3);
    read_check("ctrl_read", 32'h000, 32'h0);
    read_check("unmapped", 32'h010, 32'h0);
    apb_write(32'h008, 32'hFFFF_FFFF);
    apb_write(32'h200, 32'h0000_0FFF);
    read_check("status_ro", 32'h008, 32'h0000_0402);
    read_check("buf_ro", 32'h200, 32'h111);

    // Abort coincident with the third word
    apb_write(32'h000, 32'h1);
    strobe(12'hA01); strobe(12'hA02);
    apb_write_strobe(32'h000, 32'h2, 12'hA03);
    check("abort_disarm", {31'b0, RecSPIen}, 32'h0);
    read_check("abort_status", 32'h008, 32'h0000_0200);
    read_check("abort_buf0", 32'h200, 32'hA01);
    read_check("abort_buf1", 32'h204, 32'hA02);
    read_check("abort_buf2", 32'h208, 32'h333);

    // Restart during capture drops the coincident word
    apb_write(32'h004, 32'h1);
    apb_write(32'h000, 32'h1);
    strobe(12'hB01);
    apb_write_strobe(32'h000, 32'h1, 12'hB02);
    read_check("restart_status", 32'h008, 32'h0000_0001);
    strobe(12'hB03); strobe(12'hB04);
    read_check("restart_done", 32'h008, 32'h0000_0202);
    read_check("restart_buf0", 32'h200, 32'hB03);
    read_check("restart_buf1", 32'h204, 32'hB04);

    // Full 128-word capture wraps count to 0
    apb_write(32'h004, 32'h7F);
    apb_write(32'h000, 32'h1);
    for (int i = 0; i < 128; i++) begin
      strobe(12'(i));
      if (i == 126) check("armed_127", {31'b0, RecSPIen}, 32'h1);
    end
    check("full_disarm", {31'b0, RecSPIen}, 32'h0);
    read_check("full_status", 32'h008, 32'h0000_0002);
    read_check("full_buf127", 32'h3FC, 32'h07F);
    read_check("full_buf64", 32'h300, 32'h040);

    // Strobe outside capture sets sticky overflow
    strobe(12'hABC);
    read_check("ovf_status", 32'h008, 32'h0001_0002);
    read_check("ovf_buf0", 32'h200, 32'h000);
    apb_write(32'h000, 32'h1);
    read_check("ovf_cleared", 32'h008, 32'h0000_0001);

    // Reset mid-capture
    strobe(12'h501); strobe(12'h502); strobe(12'h503); strobe(12'h504); strobe(12'h505);
    read_check("pre_reset_status", 32'h008, 32'h0000_0501);
    @(posedge clk); #1;
    rstn = 1'b0;
    rec_valid = 1'b1;
    data_from_SPI = 12'hDDD;
    #1;
    check("async_reset_disarm", {31'b0, RecSPIen}, 32'h0);
    @(posedge clk); #1;
    rstn = 1'b1;
    rec_valid = 1'b0;
    read_check("post_reset_status", 32'h008, 32'h0);
    read_check("post_reset_len", 32'h004, 32'h7F);
    strobe(12'hEEE);
    read_check("post_reset_buf0", 32'h200, 32'h501);
    read_check("post_reset_buf4", 32'h210, 32'h505);
    read_check("post_reset_ovf", 32'h008, 32'h0001_0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
